// File: rtl/ram_cache_assoc_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_cache_assoc_if
// Brief    : CPU data port and RAM port bundle for ram_cache_assoc.
// Revision : 1.0 - initial release
// ============================================================================
interface ram_cache_assoc_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_BITS  = 10
);
    logic [DATA_WIDTH-1:0] cpu_in_m;
    logic [DATA_WIDTH-1:0] cpu_out_m;
    logic                  cpu_write_m;
    logic                  cpu_read_m;
    logic [ADDR_BITS-1:0]  cpu_data_addr;
    logic                  cpu_stall;
    logic [DATA_WIDTH-1:0] ram_in_m;
    logic [DATA_WIDTH-1:0] ram_out_m;
    logic                  ram_write_m;
    logic                  ram_read_m;
    logic [ADDR_BITS-1:0]  ram_data_addr;

    // Cache side of the bundle
    modport slave (
        input  cpu_out_m, cpu_write_m, cpu_read_m, cpu_data_addr, ram_in_m,
        output cpu_in_m, cpu_stall, ram_out_m, ram_write_m, ram_read_m, ram_data_addr
    );

    // CPU/RAM side of the bundle
    modport master (
        output cpu_out_m, cpu_write_m, cpu_read_m, cpu_data_addr, ram_in_m,
        input  cpu_in_m, cpu_stall, ram_out_m, ram_write_m, ram_read_m, ram_data_addr
    );
endinterface
`default_nettype wire

// File: rtl/ram_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : ram_cache_assoc
// Brief    : 1/2-way set-associative write-through cache, RAM fill FSM.
//            Define RAM_CACHE_STATS_EN to add hit_count/miss_count ports.
// Revision : 1.0 - initial release
// ============================================================================
module ram_cache_assoc #(
    parameter int DATA_WIDTH         = 16,
    parameter int RAM_REGISTER_COUNT = 1024,
    parameter int INDEX_BITS         = 4,
    parameter int TAG_BITS           = 2,
    parameter int WAYS               = 2,
    parameter int RAM_LATENCY        = 1
) (
    input  logic                   clk,
    input  logic                   resetN,
    ram_cache_assoc_if.slave       bus
`ifdef RAM_CACHE_STATS_EN
    ,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
`endif
);
    localparam int ADDR_BITS = $clog2(RAM_REGISTER_COUNT);
    localparam int SETS      = 1 << INDEX_BITS;
    localparam int ZERO_BITS = ADDR_BITS - INDEX_BITS - TAG_BITS;
    localparam logic [2:0] c_lat = 3'(RAM_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state, w_next;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [2:0]             r_cnt;
    logic [DATA_WIDTH-1:0]  r_hold;
    logic [DATA_WIDTH-1:0]  r_data  [WAYS][SETS];
    logic [TAG_BITS-1:0]    r_tag   [WAYS][SETS];
    logic [SETS-1:0]        r_valid [WAYS];
    logic [SETS-1:0]        r_mru;

    logic [ADDR_BITS-1:0]   w_addr;
    logic [INDEX_BITS-1:0]  w_idx;
    logic [TAG_BITS-1:0]    w_tag;
    logic                   w_cacheable;
    logic [WAYS-1:0]        w_hit_vec;
    logic                   w_hit;
    logic                   w_hit_way;
    logic                   w_victim;
    logic                   w_wr_en, w_wr_way, w_mru_en, w_mru_way;
    logic [DATA_WIDTH-1:0]  w_wr_data;
    logic                   w_start_miss, w_capture, w_rd_hit;

    // During a fill the lookup follows the latched address, otherwise the CPU address.
    assign w_addr = (r_state == S_FILL) ? r_addr : bus.cpu_data_addr;
    assign w_idx  = w_addr[INDEX_BITS-1:0];
    assign w_tag  = w_addr[INDEX_BITS +: TAG_BITS];

    generate
        if (ZERO_BITS > 0) begin : g_zero
            assign w_cacheable = (w_addr[ADDR_BITS-1 -: ZERO_BITS] == '0);
        end else begin : g_nozero
            assign w_cacheable = 1'b1;
        end

        for (genvar w = 0; w < WAYS; w++) begin : g_way
            assign w_hit_vec[w] = w_cacheable && r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag);
        end

        if (WAYS == 1) begin : g_ways1
            assign w_hit_way = 1'b0;
            assign w_victim  = 1'b0;
        end else begin : g_ways2
            assign w_hit_way = w_hit_vec[1];
            assign w_victim  = !r_valid[0][w_idx] ? 1'b0 :
                               !r_valid[1][w_idx] ? 1'b1 : ~r_mru[w_idx];
        end
    endgenerate

    assign w_hit = |w_hit_vec;

    always_comb begin
        w_next            = r_state;
        bus.cpu_stall     = 1'b0;
        bus.ram_read_m    = 1'b0;
        bus.ram_write_m   = 1'b0;
        bus.ram_out_m     = bus.cpu_out_m;
        bus.ram_data_addr = bus.cpu_data_addr;
        bus.cpu_in_m      = bus.ram_in_m;
        w_wr_en           = 1'b0;
        w_wr_way          = w_victim;
        w_wr_data         = bus.cpu_out_m;
        w_mru_en          = 1'b0;
        w_mru_way         = w_victim;
        w_start_miss      = 1'b0;
        w_capture         = 1'b0;
        w_rd_hit          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cpu_write_m) begin
                    bus.ram_write_m = 1'b1;
                    if (bus.cpu_read_m)
                        bus.cpu_in_m = bus.cpu_out_m;
                    if (w_cacheable) begin
                        w_wr_en   = 1'b1;
                        w_wr_way  = w_hit ? w_hit_way : w_victim;
                        w_mru_en  = 1'b1;
                        w_mru_way = w_wr_way;
                    end
                end else if (bus.cpu_read_m) begin
                    if (w_hit) begin
                        bus.cpu_in_m = r_data[w_hit_way][w_idx];
                        w_mru_en     = 1'b1;
                        w_mru_way    = w_hit_way;
                        w_rd_hit     = 1'b1;
                    end else begin
                        bus.cpu_stall  = 1'b1;
                        bus.ram_read_m = 1'b1;
                        w_start_miss   = 1'b1;
                        w_next         = S_FILL;
                    end
                end
            end
            S_FILL: begin
                bus.cpu_stall     = 1'b1;
                bus.ram_data_addr = r_addr;
                if (r_cnt == 3'd1) begin
                    w_capture = 1'b1;
                    w_wr_data = bus.ram_in_m;
                    if (w_cacheable) begin
                        w_wr_en  = 1'b1;
                        w_mru_en = 1'b1;
                    end
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.cpu_in_m = r_hold;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        // Reset is asynchronous, so outputs and array writes go quiet at once.
        if (!resetN) begin
            bus.cpu_stall   = 1'b0;
            bus.ram_read_m  = 1'b0;
            bus.ram_write_m = 1'b0;
            bus.cpu_in_m    = '0;
            w_wr_en         = 1'b0;
            w_mru_en        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_hold  <= '0;
            r_mru   <= '0;
            for (int w = 0; w < WAYS; w++)
                r_valid[w] <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_miss) begin
                r_addr <= bus.cpu_data_addr;
                r_cnt  <= c_lat;
            end else if (r_state == S_FILL) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (w_capture)
                r_hold <= bus.ram_in_m;
            if (w_wr_en)
                r_valid[w_wr_way][w_idx] <= 1'b1;
            if (w_mru_en)
                r_mru[w_idx] <= w_mru_way;
        end
    end

    // Payload arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_data[w_wr_way][w_idx] <= w_wr_data;
            r_tag[w_wr_way][w_idx]  <= w_tag;
        end
    end

`ifdef RAM_CACHE_STATS_EN
    logic [15:0] r_hit_count, r_miss_count;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (w_rd_hit)
                r_hit_count <= r_hit_count + 16'd1;
            if (w_start_miss)
                r_miss_count <= r_miss_count + 16'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif
endmodule
`default_nettype wire

// File: tb/tb_ram_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_cache_assoc
// Brief    : Directed self-checking bench for ram_cache_assoc (2-way, latency 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_cache_assoc;
    localparam int c_lat = 2;

    logic clk;
    logic resetN;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] ram [1024];
    logic [15:0] r_s1;

    ram_cache_assoc_if #(.DATA_WIDTH(16), .ADDR_BITS(10)) bus ();

`ifdef RAM_CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    ram_cache_assoc #(
        .DATA_WIDTH(16), .RAM_REGISTER_COUNT(1024), .INDEX_BITS(4),
        .TAG_BITS(2), .WAYS(2), .RAM_LATENCY(c_lat)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
`ifdef RAM_CACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: data appears two cycles after the read pulse.
    always @(posedge clk) begin
        r_s1         <= bus.ram_read_m ? ram[bus.ram_data_addr] : 16'h0000;
        bus.ram_in_m <= r_s1;
        if (bus.ram_write_m)
            ram[bus.ram_data_addr] <= bus.ram_out_m;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_miss(input logic [9:0] a, input logic [15:0] exp);
        bus.cpu_read_m    = 1'b1;
        bus.cpu_data_addr = a;
        @(negedge clk);
        chk("miss_stall_idle", 32'(bus.cpu_stall), 32'd1);
        chk("miss_ram_read", 32'(bus.ram_read_m), 32'd1);
        chk("miss_ram_addr", 32'(bus.ram_data_addr), 32'(a));
        for (int i = 0; i < c_lat; i++) begin
            tick();
            @(negedge clk);
            chk("fill_stall", 32'(bus.cpu_stall), 32'd1);
            chk("fill_no_read", 32'(bus.ram_read_m), 32'd0);
        end
        tick();
        @(negedge clk);
        chk("done_stall", 32'(bus.cpu_stall), 32'd0);
        chk("done_data", 32'(bus.cpu_in_m), 32'(exp));
        tick();
        bus.cpu_read_m = 1'b0;
    endtask

    task automatic read_hit(input logic [9:0] a, input logic [15:0] exp);
        bus.cpu_read_m    = 1'b1;
        bus.cpu_data_addr = a;
        @(negedge clk);
        chk("hit_stall", 32'(bus.cpu_stall), 32'd0);
        chk("hit_no_read", 32'(bus.ram_read_m), 32'd0);
        chk("hit_data", 32'(bus.cpu_in_m), 32'(exp));
        tick();
        bus.cpu_read_m = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 16'h0000;
        ram[10'h005] = 16'hBEEF;
        ram[10'h003] = 16'h0303;
        ram[10'h023] = 16'h2323;
        ram[10'h240] = 16'h4040;
        ram[10'h007] = 16'h0707;
        r_s1              = 16'h0000;
        bus.ram_in_m      = 16'h0000;
        bus.cpu_out_m     = 16'h0000;
        bus.cpu_write_m   = 1'b0;
        bus.cpu_read_m    = 1'b1;
        bus.cpu_data_addr = 10'h005;
        resetN            = 1'b0;

        // Reset state with a read request held
        @(negedge clk);
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rst_ram_read", 32'(bus.ram_read_m), 32'd0);
        chk("rst_ram_write", 32'(bus.ram_write_m), 32'd0);
        chk("rst_cpu_in", 32'(bus.cpu_in_m), 32'd0);
        tick();
        resetN         = 1'b1;
        bus.cpu_read_m = 1'b0;
        tick();

        // Scenario 1: cold miss then hit
        read_miss(10'h005, 16'hBEEF);
        read_hit(10'h005, 16'hBEEF);
`ifdef RAM_CACHE_STATS_EN
        @(negedge clk);
        chk("stats_hit_s1", 32'(hit_count), 32'd1);
        chk("stats_miss_s1", 32'(miss_count), 32'd1);
        tick();
`endif

        // Scenario 2: write allocate
        bus.cpu_write_m   = 1'b1;
        bus.cpu_data_addr = 10'h013;
        bus.cpu_out_m     = 16'h1234;
        @(negedge clk);
        chk("wr_ram_write", 32'(bus.ram_write_m), 32'd1);
        chk("wr_ram_addr", 32'(bus.ram_data_addr), 32'h013);
        chk("wr_ram_data", 32'(bus.ram_out_m), 32'h1234);
        chk("wr_stall", 32'(bus.cpu_stall), 32'd0);
        tick();
        bus.cpu_write_m = 1'b0;
        read_hit(10'h013, 16'h1234);

        // Scenario 3: LRU replacement in set 3
        read_miss(10'h003, 16'h0303);
        read_hit(10'h013, 16'h1234);
        read_hit(10'h003, 16'h0303);
        read_miss(10'h023, 16'h2323);
        read_hit(10'h003, 16'h0303);
        read_miss(10'h013, 16'h1234);

        // Scenario 4: uncacheable window
        read_miss(10'h240, 16'h4040);
        read_miss(10'h240, 16'h4040);

        // Read and write together: write wins, data forwarded
        bus.cpu_write_m   = 1'b1;
        bus.cpu_read_m    = 1'b1;
        bus.cpu_data_addr = 10'h005;
        bus.cpu_out_m     = 16'h5555;
        @(negedge clk);
        chk("rw_fwd", 32'(bus.cpu_in_m), 32'h5555);
        chk("rw_stall", 32'(bus.cpu_stall), 32'd0);
        chk("rw_no_read", 32'(bus.ram_read_m), 32'd0);
        chk("rw_ram_write", 32'(bus.ram_write_m), 32'd1);
        tick();
        bus.cpu_write_m = 1'b0;
        bus.cpu_read_m  = 1'b0;
        read_hit(10'h005, 16'h5555);
`ifdef RAM_CACHE_STATS_EN
        @(negedge clk);
        chk("stats_hit_end", 32'(hit_count), 32'd6);
        chk("stats_miss_end", 32'(miss_count), 32'd6);
        tick();
`endif

        // Scenario 5: reset during the second fill cycle
        bus.cpu_read_m    = 1'b1;
        bus.cpu_data_addr = 10'h007;
        @(negedge clk);
        chk("s5_stall_idle", 32'(bus.cpu_stall), 32'd1);
        tick();
        tick();
        resetN = 1'b0;
        #1;
        chk("s5_rst_stall", 32'(bus.cpu_stall), 32'd0);
        chk("s5_rst_read", 32'(bus.ram_read_m), 32'd0);
        tick();
        resetN         = 1'b1;
        bus.cpu_read_m = 1'b0;
        tick();
        read_miss(10'h007, 16'h0707);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
